// File: rtl/ex_mem_stage_pkg.sv
// Shared pipeline-latch definitions: stall encodings, NOP constants and the
// stage-action decode used by every EX/MEM-style boundary register.
package ex_mem_stage_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_STALL_W = 6;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  localparam logic [DEF_ADDR_W-1:0] NOP_REG_ADDR = '0;
  localparam logic [DEF_DATA_W-1:0] ZERO_WORD    = '0;

  typedef enum logic [1:0] {
    FLUSH,
    BUBBLE,
    HOLD,
    ADVANCE
  } stage_action_e;

  // The illegal "consumer stalled, producer running" case folds into HOLD.
  function automatic stage_action_e decode_action(input logic flush,
                                                  input logic upStall,
                                                  input logic dnStall);
    if (flush)                                     return FLUSH;
    if (upStall == STOP && dnStall == NOSTOP)      return BUBBLE;
    if (upStall == STOP || dnStall == STOP)        return HOLD;
    return ADVANCE;
  endfunction

endpackage

// File: rtl/ex_mem_stage_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != {W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline boundary register with flush, multi-cycle accumulator
// feedback across stalls, and saturating bubble/hold performance counters.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int CNT_W   = 2,
  parameter int STALL_W = DEF_STALL_W,
  parameter int UP_IDX  = 3,
  parameter int DN_IDX  = 4,
  parameter int PERF_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  input  logic                perf_clr,
  input  logic                ex_valid_i,
  input  logic [ADDR_W-1:0]   ex_waddr_reg_i,
  input  logic                ex_we_reg_i,
  input  logic [DATA_W-1:0]   ex_wdata_i,
  input  logic [DATA_W-1:0]   ex_hi_i,
  input  logic [DATA_W-1:0]   ex_lo_i,
  input  logic                ex_whilo_i,
  input  logic [2*DATA_W-1:0] ex_hilo_tmp_i,
  input  logic [CNT_W-1:0]    ex_cnt_i,
  output logic                mem_valid_o,
  output logic [ADDR_W-1:0]   mem_waddr_reg_o,
  output logic                mem_we_reg_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W-1:0]   mem_hi_o,
  output logic [DATA_W-1:0]   mem_lo_o,
  output logic                mem_whilo_o,
  output logic [2*DATA_W-1:0] hilo_tmp_o,
  output logic [CNT_W-1:0]    cnt_o,
  output logic [PERF_W-1:0]   bubble_cnt_o,
  output logic [PERF_W-1:0]   hold_cnt_o
);

  stage_action_e action;

  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                whilo_q, whilo_d;
  logic [2*DATA_W-1:0] hiloTmp_q, hiloTmp_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                bubbleInc, holdInc;
  logic                unusedStallBits;

  assign action          = decode_action(flush, stall[UP_IDX], stall[DN_IDX]);
  assign unusedStallBits = ^stall;

  always_comb begin
    valid_d   = valid_q;
    waddr_d   = waddr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    whilo_d   = whilo_q;
    hiloTmp_d = hiloTmp_q;
    cnt_d     = cnt_q;
    bubbleInc = 1'b0;
    holdInc   = 1'b0;

    // FLUSH and BUBBLE both present a NOP to MEM; they differ only in
    // whether the EX accumulator state is kept alive.
    if (action == FLUSH || action == BUBBLE) begin
      valid_d = 1'b0;
      waddr_d = ADDR_W'(NOP_REG_ADDR);
      we_d    = 1'b0;
      wdata_d = DATA_W'(ZERO_WORD);
      hi_d    = DATA_W'(ZERO_WORD);
      lo_d    = DATA_W'(ZERO_WORD);
      whilo_d = 1'b0;
    end

    case (action)
      FLUSH: begin
        hiloTmp_d = '0;
        cnt_d     = '0;
      end
      BUBBLE: begin
        hiloTmp_d = ex_hilo_tmp_i;
        cnt_d     = ex_cnt_i;
        bubbleInc = 1'b1;
      end
      HOLD: begin
        holdInc = 1'b1;
      end
      ADVANCE: begin
        valid_d   = ex_valid_i;
        waddr_d   = ex_waddr_reg_i;
        we_d      = ex_valid_i & ex_we_reg_i;
        wdata_d   = ex_wdata_i;
        hi_d      = ex_hi_i;
        lo_d      = ex_lo_i;
        whilo_d   = ex_valid_i & ex_whilo_i;
        hiloTmp_d = '0;
        cnt_d     = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      waddr_q   <= ADDR_W'(NOP_REG_ADDR);
      we_q      <= 1'b0;
      wdata_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      whilo_q   <= 1'b0;
      hiloTmp_q <= '0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      waddr_q   <= waddr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      whilo_q   <= whilo_d;
      hiloTmp_q <= hiloTmp_d;
      cnt_q     <= cnt_d;
    end
  end

  sat_counter #(.W(PERF_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (bubbleInc),
    .clr_i (perf_clr),
    .cnt_o (bubble_cnt_o)
  );

  sat_counter #(.W(PERF_W)) u_hold_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (holdInc),
    .clr_i (perf_clr),
    .cnt_o (hold_cnt_o)
  );

  assign mem_valid_o     = valid_q;
  assign mem_waddr_reg_o = waddr_q;
  assign mem_we_reg_o    = we_q;
  assign mem_wdata_o     = wdata_q;
  assign mem_hi_o        = hi_q;
  assign mem_lo_o        = lo_q;
  assign mem_whilo_o     = whilo_q;
  assign hilo_tmp_o      = hiloTmp_q;
  assign cnt_o           = cnt_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Table-driven bench for ex_mem_stage: expected outputs are queued when a
// vector is driven and popped one clock later when the stage has latched it.
module tb_ex_mem_stage;

  typedef struct packed {
    logic        valid;
    logic [4:0]  waddr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic [63:0] tmp;
    logic [1:0]  cnt;
    logic [15:0] bubble;
    logic [15:0] hold;
  } outs_t;

  typedef struct {
    string       name;
    logic [5:0]  stall;
    logic        flush;
    logic        clr;
    logic        valid;
    logic [4:0]  waddr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic [63:0] tmp;
    logic [1:0]  cnt;
    outs_t       exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush, perfClr, exValid, exWe, exWhilo;
  logic [4:0]  exWaddr;
  logic [31:0] exWdata, exHi, exLo;
  logic [63:0] exTmp;
  logic [1:0]  exCnt;

  logic        memValid, memWe, memWhilo;
  logic [4:0]  memWaddr;
  logic [31:0] memWdata, memHi, memLo;
  logic [63:0] hiloTmp;
  logic [1:0]  cntOut;
  logic [15:0] bubbleCnt, holdCnt;

  int    testsRun = 0;
  int    testsFailed = 0;
  outs_t expQ[$];
  string nameQ[$];
  vec_t  vecs[12];
  vec_t  v;

  ex_mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .perf_clr        (perfClr),
    .ex_valid_i      (exValid),
    .ex_waddr_reg_i  (exWaddr),
    .ex_we_reg_i     (exWe),
    .ex_wdata_i      (exWdata),
    .ex_hi_i         (exHi),
    .ex_lo_i         (exLo),
    .ex_whilo_i      (exWhilo),
    .ex_hilo_tmp_i   (exTmp),
    .ex_cnt_i        (exCnt),
    .mem_valid_o     (memValid),
    .mem_waddr_reg_o (memWaddr),
    .mem_we_reg_o    (memWe),
    .mem_wdata_o     (memWdata),
    .mem_hi_o        (memHi),
    .mem_lo_o        (memLo),
    .mem_whilo_o     (memWhilo),
    .hilo_tmp_o      (hiloTmp),
    .cnt_o           (cntOut),
    .bubble_cnt_o    (bubbleCnt),
    .hold_cnt_o      (holdCnt)
  );

  always #5 clk = ~clk;

  // The stall controller must never stall MEM while EX runs.
  always @(posedge clk) begin
    if (!rst)
      assert (!(stall[4] && !stall[3]))
        else $error("[TB] FAIL illegalStall stall=%b", stall);
  end

  function automatic outs_t mkExp(input logic va, input logic [4:0] a, input logic we,
                                  input logic [31:0] d, input logic [31:0] h, input logic [31:0] l,
                                  input logic wh, input logic [63:0] t, input logic [1:0] c,
                                  input logic [15:0] b, input logic [15:0] ho);
    outs_t o;
    o = '{valid: va, waddr: a, we: we, wdata: d, hi: h, lo: l, whilo: wh,
          tmp: t, cnt: c, bubble: b, hold: ho};
    return o;
  endfunction

  function automatic vec_t mkVec(input string n, input logic [5:0] s, input logic f,
                                 input logic cl, input logic va, input logic [4:0] a,
                                 input logic we, input logic [31:0] d, input logic [31:0] h,
                                 input logic [31:0] l, input logic wh, input logic [63:0] t,
                                 input logic [1:0] c, input outs_t e);
    vec_t r;
    r.name = n; r.stall = s; r.flush = f; r.clr = cl; r.valid = va; r.waddr = a;
    r.we = we; r.wdata = d; r.hi = h; r.lo = l; r.whilo = wh; r.tmp = t; r.cnt = c;
    r.exp = e;
    return r;
  endfunction

  function automatic outs_t sampleDut();
    outs_t o;
    o = '{valid: memValid, waddr: memWaddr, we: memWe, wdata: memWdata, hi: memHi,
          lo: memLo, whilo: memWhilo, tmp: hiloTmp, cnt: cntOut, bubble: bubbleCnt,
          hold: holdCnt};
    return o;
  endfunction

  task automatic driveInputs(input vec_t s);
    stall = s.stall; flush = s.flush; perfClr = s.clr; exValid = s.valid;
    exWaddr = s.waddr; exWe = s.we; exWdata = s.wdata; exHi = s.hi; exLo = s.lo;
    exWhilo = s.whilo; exTmp = s.tmp; exCnt = s.cnt;
  endtask

  task automatic applyStimulus(input vec_t s);
    driveInputs(s);
    expQ.push_back(s.exp);
    nameQ.push_back(s.name);
  endtask

  task automatic compareNow();
    outs_t act, exp;
    string n;
    testsRun++;
    if (expQ.size() == 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboardEmpty: output produced with nothing expected");
      return;
    end
    exp = expQ.pop_front();
    n = nameQ.pop_front();
    act = sampleDut();
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic checkOutput();
    @(posedge clk);
    #1;
    compareNow();
  endtask

  initial begin
    outs_t zeroOut;
    vec_t  idle, bub;
    zeroOut = '0;
    idle = mkVec("idle", 6'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0, zeroOut);
    bub  = mkVec("bubble", 6'b001000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0, zeroOut);

    vecs[0]  = mkVec("advance", 6'b000000, 0, 0, 1, 5'd3, 1, 32'h12345678, 32'h11111111, 32'h22222222, 1, 64'h0, 2'd0,
                     mkExp(1, 5'd3, 1, 32'h12345678, 32'h11111111, 32'h22222222, 1, 64'h0, 2'd0, 16'd0, 16'd0));
    vecs[1]  = mkVec("bubbleCarry", 6'b001000, 0, 0, 1, 5'd7, 1, 32'h99, 32'h1, 32'h2, 1, 64'h0000_0001_0000_0002, 2'd1,
                     mkExp(0, 5'd0, 0, 32'h0, 32'h0, 32'h0, 0, 64'h0000_0001_0000_0002, 2'd1, 16'd1, 16'd0));
    vecs[2]  = mkVec("advanceClrTmp", 6'b000000, 0, 0, 1, 5'd9, 0, 32'hA5A5A5A5, 32'h0, 32'h0, 0, 64'h55, 2'd2,
                     mkExp(1, 5'd9, 0, 32'hA5A5A5A5, 32'h0, 32'h0, 0, 64'h0, 2'd0, 16'd1, 16'd0));
    for (int i = 0; i < 3; i++)
      vecs[3+i] = mkVec("hold", 6'b011000, 0, 0, 0, 5'd31, 1, 32'hFFFFFFFF, 32'h3, 32'h4, 1, 64'hFFFF, 2'd3,
                        mkExp(1, 5'd9, 0, 32'hA5A5A5A5, 32'h0, 32'h0, 0, 64'h0, 2'd0, 16'd1, 16'(i + 1)));
    vecs[6]  = mkVec("flushOverBubble", 6'b001000, 1, 0, 1, 5'd4, 1, 32'h1, 32'h1, 32'h1, 1, 64'h77, 2'd3,
                     mkExp(0, 5'd0, 0, 32'h0, 32'h0, 32'h0, 0, 64'h0, 2'd0, 16'd1, 16'd3));
    vecs[7]  = mkVec("invalidSuppress", 6'b000000, 0, 0, 0, 5'd6, 1, 32'hCAFEF00D, 32'h1, 32'h2, 1, 64'h0, 2'd0,
                     mkExp(0, 5'd6, 0, 32'hCAFEF00D, 32'h1, 32'h2, 0, 64'h0, 2'd0, 16'd1, 16'd3));
    vecs[8]  = mkVec("clrWithFlush", 6'b000000, 1, 1, 1, 5'd2, 1, 32'h5, 32'h5, 32'h5, 1, 64'h0, 2'd0,
                     mkExp(0, 5'd0, 0, 32'h0, 32'h0, 32'h0, 0, 64'h0, 2'd0, 16'd0, 16'd0));
    vecs[9]  = mkVec("bubbleAfterClr", 6'b001000, 0, 0, 1, 5'd8, 1, 32'h8, 32'h8, 32'h8, 1, 64'hABCD, 2'd2,
                     mkExp(0, 5'd0, 0, 32'h0, 32'h0, 32'h0, 0, 64'hABCD, 2'd2, 16'd1, 16'd0));
    vecs[10] = mkVec("holdKeepsTmp", 6'b011000, 0, 0, 1, 5'd8, 1, 32'h8, 32'h8, 32'h8, 1, 64'h1234, 2'd1,
                     mkExp(0, 5'd0, 0, 32'h0, 32'h0, 32'h0, 0, 64'hABCD, 2'd2, 16'd1, 16'd1));
    vecs[11] = mkVec("clrDuringHold", 6'b011000, 0, 1, 1, 5'd8, 1, 32'h8, 32'h8, 32'h8, 1, 64'h1234, 2'd1,
                     mkExp(0, 5'd0, 0, 32'h0, 32'h0, 32'h0, 0, 64'hABCD, 2'd2, 16'd0, 16'd0));

    rst = 1'b1;
    driveInputs(idle);
    #12;
    rst = 1'b0;
    expQ.push_back(zeroOut);
    nameQ.push_back("resetState");
    compareNow();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput();
    end

    // Asynchronous reset between edges must clear everything at once.
    v = mkVec("preResetLoad", 6'b0, 0, 0, 1, 5'd5, 1, 32'hDEADBEEF, 32'h0, 32'h0, 0, 64'h0, 2'd0,
              mkExp(1, 5'd5, 1, 32'hDEADBEEF, 32'h0, 32'h0, 0, 64'h0, 2'd0, 16'd0, 16'd0));
    applyStimulus(v);
    checkOutput();
    driveInputs(idle);
    #2;
    rst = 1'b1;
    #1;
    expQ.push_back(zeroOut);
    nameQ.push_back("asyncResetMidRun");
    compareNow();
    #2;
    rst = 1'b0;

    // Saturation: 65535 bubbles reach all-ones, one more must not wrap.
    driveInputs(bub);
    repeat (65534) @(posedge clk);
    #1;
    bub.exp = mkExp(0, 5'd0, 0, 32'h0, 32'h0, 32'h0, 0, 64'h0, 2'd0, 16'hFFFF, 16'd0);
    bub.name = "bubbleReachMax";
    applyStimulus(bub);
    checkOutput();
    bub.name = "bubbleSaturate";
    applyStimulus(bub);
    checkOutput();
    v = idle;
    v.clr = 1'b1;
    v.name = "perfClrAfterSat";
    applyStimulus(v);
    checkOutput();

    if (expQ.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL scoreboardLeftover: got %0d pending entries expected 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
